// File: rtl/am_search_controller_if.sv
// Purpose : query/AM-read/comparator bundle for one associative-memory search.
// Latency : n/a (wires only).
// Backpressure: none; start is a request and is dropped while a search runs.
// Ports   : master = controller (drives busy, AM read address/strobe, similarity
//           array, inferring_class, done); slave = environment (drives start,
//           partial_valid/partial_sim returned by the AM popcount pipeline).
interface am_search_controller_if #(
    parameter int NUM_CLASSES = 26,
    parameter int NUM_CHUNKS  = 20,
    parameter int PSUM_W      = 9,
    parameter int SIM_W       = 13
);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CHK_W = $clog2(NUM_CHUNKS);

    logic                               start;
    logic                               busy;
    logic                               am_rd_en;
    logic [CLS_W-1:0]                   am_class_addr;
    logic [CHK_W-1:0]                   am_chunk_addr;
    logic                               partial_valid;
    logic [PSUM_W-1:0]                  partial_sim;
    logic [NUM_CLASSES-1:0][SIM_W-1:0]  similarity_values;
    logic                               inferring_class;
    logic                               done;

    modport master (
        input  start, partial_valid, partial_sim,
        output busy, am_rd_en, am_class_addr, am_chunk_addr,
               similarity_values, inferring_class, done
    );

    modport slave (
        output start, partial_valid, partial_sim,
        input  busy, am_rd_en, am_class_addr, am_chunk_addr,
               similarity_values, inferring_class, done
    );
endinterface

// File: rtl/am_search_controller.sv
// Purpose : sequences one AM search per query: reads every class x chunk, sums
//           per-chunk overlaps into saturating per-class similarity registers,
//           strobes the tree comparator, then pulses done.
// Latency : start accepted at edge 0 -> done high in cycle NUM_CLASSES*NUM_CHUNKS+3.
// Backpressure: none; start is ignored unless IDLE, AM data must follow each read
//           by exactly one cycle.
// Ports   : clk, nrst (async active-low), bus (am_search_controller_if.master).
module am_search_controller #(
    parameter int NUM_CLASSES = 26,
    parameter int NUM_CHUNKS  = 20,
    parameter int PSUM_W      = 9,
    parameter int SIM_W       = 13
) (
    input logic                     clk,
    input logic                     nrst,
    am_search_controller_if.master  bus
);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CHK_W = $clog2(NUM_CHUNKS);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        INFER,
        FIN
    } state_t;

    state_t           state;
    // Class address of the previous read; the AM returns its popcount one cycle later.
    logic [CLS_W-1:0] tag_class;
    logic [SIM_W:0]   acc_sum;
    logic             last_read;

    // One extra bit catches the carry so saturation never wraps.
    assign acc_sum   = {1'b0, bus.similarity_values[tag_class]} + (SIM_W+1)'(bus.partial_sim);
    assign last_read = (bus.am_class_addr == CLS_W'(NUM_CLASSES - 1)) &&
                       (bus.am_chunk_addr == CHK_W'(NUM_CHUNKS - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                 <= IDLE;
            tag_class             <= '0;
            bus.busy              <= 1'b0;
            bus.am_rd_en          <= 1'b0;
            bus.am_class_addr     <= '0;
            bus.am_chunk_addr     <= '0;
            bus.inferring_class   <= 1'b0;
            bus.done              <= 1'b0;
            bus.similarity_values <= '0;
        end else begin
            // Accumulation runs outside IDLE so the final partial lands in DRAIN.
            // A stray partial_valid only touches the similarity array, never the FSM.
            if (state != IDLE && bus.partial_valid) begin
                bus.similarity_values[tag_class] <= acc_sum[SIM_W] ? {SIM_W{1'b1}}
                                                                   : acc_sum[SIM_W-1:0];
            end
            if (bus.am_rd_en) begin
                tag_class <= bus.am_class_addr;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.similarity_values <= '0;
                        bus.am_class_addr     <= '0;
                        bus.am_chunk_addr     <= '0;
                        bus.am_rd_en          <= 1'b1;
                        bus.busy              <= 1'b1;
                        state                 <= SCAN;
                    end
                end
                SCAN: begin
                    if (last_read) begin
                        bus.am_rd_en <= 1'b0;
                        state        <= DRAIN;
                    end else if (bus.am_chunk_addr == CHK_W'(NUM_CHUNKS - 1)) begin
                        bus.am_chunk_addr <= '0;
                        bus.am_class_addr <= bus.am_class_addr + 1'b1;
                    end else begin
                        bus.am_chunk_addr <= bus.am_chunk_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    bus.inferring_class <= 1'b1;
                    state               <= INFER;
                end
                INFER: begin
                    bus.inferring_class <= 1'b0;
                    bus.done            <= 1'b1;
                    state               <= FIN;
                end
                FIN: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
